// File: rtl/kmc_brg_bank.sv
// Bank of NREG branch registers for the KMC microsequencer.
// Supports load, single-step shifts and rotates, and a multi-cycle rotate-by-N (RORN).
module kmc_brg_bank #(
    parameter int WIDTH = 8,
    parameter int NREG  = 2,
    parameter int CNTW  = 4,
    localparam int SELW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  clken,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [SELW-1:0]       sel,
    input  logic [WIDTH-1:0]      din,
    input  logic [CNTW-1:0]       cnt,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      q,
    output logic [NREG*WIDTH-1:0] brg_all,
    output logic                  cy,
    output logic                  zero,
    output logic                  msb,
    output logic                  lsb
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ROR  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_ASR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_RORN = 3'd7;

    typedef enum logic [1:0] {IDLE, ROT, FIN} state_t;

    state_t                      state, state_nxt;
    logic [NREG-1:0][WIDTH-1:0]  r;
    logic [SELW-1:0]             rsel;
    logic [CNTW-1:0]             rem;
    logic [WIDTH-1:0]            cur, rcur;
    logic                        accept, is_rorn, sel_ok, rsel_ok, clr;

    assign clr     = rst | init;
    assign accept  = clken & start & (state == IDLE);
    assign is_rorn = (op == OP_RORN);
    assign sel_ok  = 32'(sel) < 32'(NREG);
    assign rsel_ok = 32'(rsel) < 32'(NREG);

    // Unpopulated select codes read as zero.
    always_comb begin
        cur  = '0;
        rcur = '0;
        if (sel_ok)  cur  = r[sel];
        if (rsel_ok) rcur = r[rsel];
    end

    assign q       = cur;
    assign brg_all = r;
    assign zero    = (cur == '0);
    assign msb     = cur[WIDTH-1];
    assign lsb     = cur[0];
    assign busy    = (state == ROT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_rorn) state_nxt = (cnt != '0) ? ROT : FIN;
            ROT:     if (clken && rem == CNTW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r    <= '0;
            cy   <= 1'b0;
            done <= 1'b0;
            rsel <= '0;
            rem  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (!is_rorn || cnt == '0) begin
                    done <= 1'b1;
                end else begin
                    rsel <= sel;
                    rem  <= cnt;
                end
                if (sel_ok) begin
                    case (op)
                        OP_LOAD: r[sel] <= din;
                        OP_ROR: begin
                            r[sel] <= {din[0], din[WIDTH-1:1]};
                            cy     <= din[0];
                        end
                        OP_SHR: begin
                            r[sel] <= {1'b0, cur[WIDTH-1:1]};
                            cy     <= cur[0];
                        end
                        OP_ASR: begin
                            r[sel] <= {cur[WIDTH-1], cur[WIDTH-1:1]};
                            cy     <= cur[0];
                        end
                        OP_ROL: begin
                            r[sel] <= {cur[WIDTH-2:0], cur[WIDTH-1]};
                            cy     <= cur[WIDTH-1];
                        end
                        OP_SHL: begin
                            r[sel] <= {cur[WIDTH-2:0], 1'b0};
                            cy     <= cur[WIDTH-1];
                        end
                        OP_NOP, OP_RORN: ;
                        default: ;
                    endcase
                end
            end else if (state == ROT && clken) begin
                rem <= rem - CNTW'(1);
                // Last step raises done so it is high during the FIN cycle.
                if (rem == CNTW'(1)) done <= 1'b1;
                if (rsel_ok) begin
                    r[rsel] <= {rcur[0], rcur[WIDTH-1:1]};
                    cy      <= rcur[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_kmc_brg_bank.sv
// Bench for kmc_brg_bank: scoreboard of expected register/carry results checked at each done pulse,
// plus per-scenario checks of handshake timing and flag outputs.
module tb_kmc_brg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, init, clken, start;
    logic [2:0]  op;
    logic        sel;
    logic [7:0]  din;
    logic [3:0]  cnt;
    logic        busy, done, cy, zero, msb, lsb;
    logic [7:0]  q;
    logic [15:0] brg_all;

    logic        b_clken, b_start;
    logic [2:0]  b_op;
    logic [1:0]  b_sel;
    logic [15:0] b_din;
    logic [3:0]  b_cnt;
    logic        b_busy, b_done, b_cy, b_zero, b_msb, b_lsb;
    logic [15:0] b_q;
    logic [63:0] b_all;

    kmc_brg_bank #(.WIDTH(8), .NREG(2), .CNTW(4)) dut (
        .clk(clk), .rst(rst), .init(init), .clken(clken), .start(start), .op(op),
        .sel(sel), .din(din), .cnt(cnt), .busy(busy), .done(done), .q(q),
        .brg_all(brg_all), .cy(cy), .zero(zero), .msb(msb), .lsb(lsb)
    );

    kmc_brg_bank #(.WIDTH(16), .NREG(4), .CNTW(4)) dut_w (
        .clk(clk), .rst(rst), .init(init), .clken(b_clken), .start(b_start), .op(b_op),
        .sel(b_sel), .din(b_din), .cnt(b_cnt), .busy(b_busy), .done(b_done), .q(b_q),
        .brg_all(b_all), .cy(b_cy), .zero(b_zero), .msb(b_msb), .lsb(b_lsb)
    );

    typedef struct {
        int         s;
        logic [7:0] v;
        logic       c;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Scoreboard: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_done: done=1 with no op pending, expected done=0");
            end else begin
                mon_e = sbq.pop_front();
                if (brg_all[mon_e.s*8 +: 8] !== mon_e.v || cy !== mon_e.c) begin
                    miscompares++;
                    $display("FAIL sb_result: R%0d=%h cy=%b, expected R%0d=%h cy=%b",
                             mon_e.s, brg_all[mon_e.s*8 +: 8], cy, mon_e.s, mon_e.v, mon_e.c);
                end
            end
        end
    end

    task automatic push(input int s, input logic [7:0] v, input logic c);
        exp_t e;
        e.s = s; e.v = v; e.c = c;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic s, input logic [7:0] d, input logic [3:0] c);
        op = o; sel = s; din = d; cnt = c; start = 1'b1; clken = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; init = 1'b0; clken = 1'b0; start = 1'b0; op = '0; sel = '0; din = '0; cnt = '0;
        b_clken = 1'b0; b_start = 1'b0; b_op = '0; b_sel = '0; b_din = '0; b_cnt = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        vectors++; if (brg_all !== 16'h0) begin miscompares++; $display("FAIL rst_regs: %h, expected 0000", brg_all); end
        vectors++; if (cy !== 1'b0)       begin miscompares++; $display("FAIL rst_cy: %b, expected 0", cy); end
        vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL rst_busy: %b, expected 0", busy); end
        vectors++; if (done !== 1'b0)     begin miscompares++; $display("FAIL rst_done: %b, expected 0", done); end
        vectors++; if (b_all !== 64'h0)   begin miscompares++; $display("FAIL rst_wide_regs: %h, expected 0", b_all); end
        push(0, 8'hA5, 1'b0);
        issue(3'd1, 1'b0, 8'hA5, 4'd0);
        issue(3'd7, 1'b0, 8'h00, 4'd5);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rorn_busy_start: %b, expected 1", busy); end
        repeat (2) begin @(posedge clk); #1; end
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        vectors++; if (brg_all !== 16'h0) begin miscompares++; $display("FAIL init_regs: %h, expected 0000", brg_all); end
        vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL init_busy: %b, expected 0", busy); end
        vectors++; if (cy !== 1'b0)       begin miscompares++; $display("FAIL init_cy: %b, expected 0", cy); end
        n = 0;
        repeat (8) begin
            if (done === 1'b1) n++;
            @(posedge clk); #1;
        end
        vectors++; if (n != 0) begin miscompares++; $display("FAIL init_no_done: %0d pulses, expected 0", n); end
    endtask

    task automatic test_load_ror();
        push(1, 8'h3C, 1'b0);
        issue(3'd1, 1'b1, 8'h3C, 4'd0);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL load_done: %b, expected 1", done); end
        vectors++; if (q !== 8'h3C)   begin miscompares++; $display("FAIL load_q: %h, expected 3c", q); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL load_done_width: %b, expected 0", done); end
        push(1, 8'hC0, 1'b1);
        issue(3'd2, 1'b1, 8'h81, 4'd0);
        vectors++; if (msb !== 1'b1 || lsb !== 1'b0 || zero !== 1'b0) begin
            miscompares++; $display("FAIL ror_flags: msb=%b lsb=%b zero=%b, expected 1 0 0", msb, lsb, zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_shifts();
        push(0, 8'h81, 1'b1); issue(3'd1, 1'b0, 8'h81, 4'd0);
        push(0, 8'h40, 1'b1); issue(3'd3, 1'b0, 8'h00, 4'd0);
        push(0, 8'h20, 1'b0); issue(3'd3, 1'b0, 8'h00, 4'd0);
        push(0, 8'h81, 1'b0); issue(3'd1, 1'b0, 8'h81, 4'd0);
        push(0, 8'hC0, 1'b1); issue(3'd4, 1'b0, 8'h00, 4'd0);
        push(0, 8'h81, 1'b1); issue(3'd1, 1'b0, 8'h81, 4'd0);
        push(0, 8'h02, 1'b1); issue(3'd6, 1'b0, 8'h00, 4'd0);
        push(0, 8'h04, 1'b0); issue(3'd6, 1'b0, 8'h00, 4'd0);
        push(0, 8'h81, 1'b0); issue(3'd1, 1'b0, 8'h81, 4'd0);
        push(0, 8'h03, 1'b1); issue(3'd5, 1'b0, 8'h00, 4'd0);
        push(0, 8'h03, 1'b1); issue(3'd0, 1'b0, 8'hFF, 4'd0);
        @(posedge clk); #1;
    endtask

    task automatic test_rorn();
        logic pat [4];
        int busy_n, done_n;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        busy_n = 0; done_n = 0;
        push(0, 8'h01, 1'b1); issue(3'd1, 1'b0, 8'h01, 4'd0);
        push(0, 8'h20, 1'b0); issue(3'd7, 1'b0, 8'h00, 4'd3);
        for (int i = 0; i < 4; i++) begin
            clken = pat[i];
            if (i == 2) begin start = 1'b1; op = 3'd1; sel = 1'b1; din = 8'hFF; end
            else start = 1'b0;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) done_n++;
            @(posedge clk); #1;
        end
        vectors++; if (busy_n != 4) begin miscompares++; $display("FAIL rorn_busy_cycles: %0d, expected 4", busy_n); end
        vectors++; if (done_n != 0) begin miscompares++; $display("FAIL rorn_early_done: %0d, expected 0", done_n); end
        vectors++; if (busy !== 1'b0 || done !== 1'b1) begin
            miscompares++; $display("FAIL rorn_fin: busy=%b done=%b, expected 0 1", busy, done);
        end
        start = 1'b1; op = 3'd1; sel = 1'b1; din = 8'hFF; clken = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rorn_single_done: %b, expected 0", done); end
        vectors++; if (brg_all[15:8] !== 8'hC0) begin
            miscompares++; $display("FAIL rorn_start_ignored: R1=%h, expected c0", brg_all[15:8]);
        end
    endtask

    task automatic test_rorn_edge();
        int n;
        push(1, 8'hC0, 1'b0); issue(3'd7, 1'b1, 8'h00, 4'd0);
        vectors++; if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rorn0_done: done=%b busy=%b, expected 1 0", done, busy);
        end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rorn0_done_width: %b, expected 0", done); end
        push(0, 8'h96, 1'b0); issue(3'd1, 1'b0, 8'h96, 4'd0);
        push(0, 8'h96, 1'b1); issue(3'd7, 1'b0, 8'h00, 4'd8);
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        vectors++; if (n != 8) begin miscompares++; $display("FAIL rorn8_latency: %0d cycles, expected 8", n); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        push(1, 8'h55, 1'b1);
        push(1, 8'hAA, 1'b0);
        op = 3'd1; sel = 1'b1; din = 8'h55; start = 1'b1; clken = 1'b1;
        @(posedge clk); #1;
        op = 3'd6;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_second_done: %b, expected 1", done); end
        @(posedge clk); #1;
        clken = 1'b0; start = 1'b1; op = 3'd1; sel = 1'b1; din = 8'hFF;
        repeat (2) begin @(posedge clk); #1; end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL clken_gate_done: %b, expected 0", done); end
        start = 1'b0; clken = 1'b1;
        vectors++; if (brg_all[15:8] !== 8'hAA) begin
            miscompares++; $display("FAIL clken_gate_reg: R1=%h, expected aa", brg_all[15:8]);
        end
    endtask

    task automatic test_wide();
        b_op = 3'd1; b_sel = 2'd3; b_din = 16'h8001; b_start = 1'b1; b_clken = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        vectors++; if (b_done !== 1'b1) begin miscompares++; $display("FAIL wide_done: %b, expected 1", b_done); end
        vectors++; if (b_all[63:48] !== 16'h8001) begin
            miscompares++; $display("FAIL wide_all: %h, expected 8001", b_all[63:48]);
        end
        vectors++; if (b_q !== 16'h8001 || b_msb !== 1'b1 || b_lsb !== 1'b1 || b_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL wide_flags: q=%h msb=%b lsb=%b zero=%b, expected 8001 1 1 0", b_q, b_msb, b_lsb, b_zero);
        end
        b_sel = 2'd2; #1;
        vectors++; if (b_zero !== 1'b1 || b_q !== 16'h0) begin
            miscompares++; $display("FAIL wide_sel2: q=%h zero=%b, expected 0000 1", b_q, b_zero);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_ror();
        test_shifts();
        test_rorn();
        test_rorn_edge();
        test_back_to_back();
        test_wide();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (sbq.size() != 0) begin
            miscompares++; $display("FAIL sb_drain: %0d results pending, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
